// File: rtl/vc_dom_pkg.sv
// Shared definitions for the domain-aware round-robin mux: output register
// state encoding and security domain labels.
package vc_dom_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SCRUB = 2'd2
  } state_e;

  localparam logic DOM_L = 1'b0;
  localparam logic DOM_H = 1'b1;

endpackage

// File: rtl/vc_dom_rr_arb.sv
// Combinational round-robin arbiter: picks the first valid channel at or
// after ptr_i, wrapping to the lowest valid channel when none is found.
module vc_dom_rr_arb #(
  parameter int p_nchan = 4,
  parameter int p_cw    = $clog2(p_nchan)
) (
  input  logic [p_nchan-1:0] in_val_i,
  input  logic [p_cw-1:0]    ptr_i,
  output logic [p_cw-1:0]    winner_o,
  output logic               any_o
);

  logic [p_cw-1:0] lo_idx;
  logic [p_cw-1:0] hi_idx;
  logic            hi_any;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    lo_idx = '0;
    hi_idx = '0;
    hi_any = 1'b0;
    any_o  = 1'b0;
    // Descending scan: the last hit is the lowest index in each half.
    for (int i = p_nchan - 1; i >= 0; i--) begin
      if (in_val_i[i]) begin
        any_o  = 1'b1;
        lo_idx = p_cw'(i);
        if (p_cw'(i) >= ptr_i) begin
          hi_any = 1'b1;
          hi_idx = p_cw'(i);
        end
      end
    end
    winner_o = hi_any ? hi_idx : lo_idx;
  end

endmodule

// File: rtl/vc_dom_rr_mux.sv
// Round-robin N:1 mux with a one-entry output register labelled by security domain.
// Define VC_DOM_RR_MUX_SCRUB_EN to insert a one-cycle scrub on high-to-low domain switches.
module vc_dom_rr_mux
  import vc_dom_pkg::*;
#(
  parameter int p_nbits = 32,
  parameter int p_nchan = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [p_nchan-1:0]         in_val,
  output logic [p_nchan-1:0]         in_rdy,
  input  logic [p_nchan*p_nbits-1:0] in_msg,
  input  logic [p_nchan-1:0]         in_domain,
  output logic                       out_val,
  input  logic                       out_rdy,
  output logic [p_nbits-1:0]         out_msg,
  output logic                       out_domain,
  output logic [$clog2(p_nchan)-1:0] out_chan
);

  localparam int CW = $clog2(p_nchan);

  state_e          state_q, state_d;
  logic [CW-1:0]   ptr_q, ptr_d;
  logic [p_nbits-1:0] msg_q, msg_d;
  logic            dom_q, dom_d;
  logic [CW-1:0]   chan_q, chan_d;

  logic [CW-1:0]   winner;
  logic            any_val;
  logic [p_nbits-1:0] msg_sel;
  logic            dom_sel;
  logic            accept_en;
  logic            scrub;
  logic            fire;

  vc_dom_rr_arb #(
    .p_nchan (p_nchan),
    .p_cw    (CW)
  ) u_arb (
    .in_val_i (in_val),
    .ptr_i    (ptr_q),
    .winner_o (winner),
    .any_o    (any_val)
  );

  always_comb begin
    msg_sel = '0;
    dom_sel = DOM_L;
    for (int i = 0; i < p_nchan; i++) begin
      if (winner == CW'(i)) begin
        msg_sel = in_msg[i*p_nbits +: p_nbits];
        dom_sel = in_domain[i];
      end
    end
  end

  assign accept_en = (state_q == EMPTY) || ((state_q == FULL) && out_rdy);

`ifdef VC_DOM_RR_MUX_SCRUB_EN
  // High-domain data must never be followed directly by low-domain data.
  assign scrub = accept_en && any_val && (dom_q == DOM_H) && (dom_sel == DOM_L);
`else
  assign scrub = 1'b0;
`endif

  // Gated by reset_n so no ready is offered while reset is asserted.
  assign fire = reset_n && accept_en && any_val && !scrub;

  always_comb begin
    for (int i = 0; i < p_nchan; i++) begin
      in_rdy[i] = fire && (winner == CW'(i));
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    msg_d   = msg_q;
    dom_d   = dom_q;
    chan_d  = chan_q;
    unique case (state_q)
      EMPTY, FULL: begin
        if (fire) begin
          state_d = FULL;
          msg_d   = msg_sel;
          dom_d   = dom_sel;
          chan_d  = winner;
          ptr_d   = (winner == CW'(p_nchan - 1)) ? '0 : winner + CW'(1);
        end else if (scrub) begin
          state_d = SCRUB;
          msg_d   = '0;
          dom_d   = DOM_L;
        end else if ((state_q == FULL) && out_rdy) begin
          state_d = EMPTY;
          msg_d   = '0;
        end
      end
      SCRUB:   state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the message register is reset as well, so no stale high-domain data is ever visible.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      msg_q   <= '0;
      dom_q   <= DOM_L;
      chan_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      msg_q   <= msg_d;
      dom_q   <= dom_d;
      chan_q  <= chan_d;
    end
  end

  assign out_val    = (state_q == FULL);
  assign out_msg    = msg_q;
  assign out_domain = dom_q;
  assign out_chan   = chan_q;

endmodule
